// File: rtl/wptr_full.sv
// Write-side pointer and full/almost-full/count/overflow logic of an async FIFO.
// wen is combinational from winc and wfull; flags update one wclk edge later. A write that arrives while wfull=1 is dropped and sets woverflow.
module wptr_full #(
    parameter int ASIZE        = 3,
    parameter int AFULL_THRESH = 2
) (
    input  logic             wclk,
    input  logic             in_resetn,
    input  logic             winc,
    input  logic             wovf_clr,
    input  logic [ASIZE:0]   wq2_rptr,
    output logic [ASIZE:0]   wptr,
    output logic [ASIZE-1:0] waddr,
    output logic             wen,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wcount,
    output logic             woverflow
);

    localparam logic [ASIZE:0] AF_LEVEL = (ASIZE+1)'((2 ** ASIZE) - AFULL_THRESH);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] rbin_s;
    logic [ASIZE:0] wdiff;
    logic [ASIZE:0] full_ptr;

    assign wen        = winc & ~wfull;
    assign waddr      = wbin[ASIZE-1:0];
    assign wbin_next  = wbin + {{ASIZE{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Each binary bit is the XOR of the Gray bits at and above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    assign wdiff    = wbin_next - rbin_s;
    // Gray value of the read pointer advanced by one full lap of the memory.
    assign full_ptr = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};

    always_ff @(posedge wclk or negedge in_resetn) begin
        if (!in_resetn) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_ptr);
            walmost_full <= (wdiff >= AF_LEVEL);
            wcount       <= wdiff;
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule
